// File: rtl/window_apply.sv
// Triangle-window multiplier ahead of the FFT: joins sample and coefficient
// streams beat-for-beat, then rounds and saturates the product over a 2-stage pipeline.
module window_apply #(
    parameter int SAMPLE_WIDTH    = 16,
    parameter int WIN_POW2        = 10,
    parameter int OUT_WIDTH       = 16,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [SAMPLE_WIDTH-1:0]    sample_in,
    input  logic                              sample_in_valid,
    output logic                              sample_in_ready,
    input  logic        [WIN_POW2-1:0]        win_in,
    input  logic                              win_in_valid,
    input  logic                              win_in_last,
    output logic                              win_in_ready,
    output logic signed [OUT_WIDTH-1:0]       data_out,
    output logic                              data_out_valid,
    output logic                              data_out_last,
    input  logic                              data_out_ready,
    output logic        [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int PROD_W = SAMPLE_WIDTH + WIN_POW2 + 1;

    // Constants at the rounding width (one guard bit above the product).
    localparam logic signed [PROD_W:0] RND_HALF =
        {{(PROD_W - WIN_POW2 + 2){1'b0}}, 1'b1, {(WIN_POW2 - 2){1'b0}}};
    localparam logic signed [PROD_W:0] OUT_MAX =
        {{(PROD_W - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [PROD_W:0] OUT_MIN =
        {{(PROD_W - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // Round half-up to the 1.0 = 2**(WIN_POW2-1) scale, then clamp to the output range.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W:0] r;
        r = {p[PROD_W-1], p} + RND_HALF;
        r = r >>> (WIN_POW2 - 1);
        if (r > OUT_MAX) begin
            return OUT_MAX[OUT_WIDTH-1:0];
        end
        if (r < OUT_MIN) begin
            return OUT_MIN[OUT_WIDTH-1:0];
        end
        return r[OUT_WIDTH-1:0];
    endfunction

    logic                              vld_p1_q;
    logic                              last_p1_q;
    logic signed [PROD_W-1:0]          prod_p1_q;
    logic signed [PROD_W-1:0]          prod_p1_d;
    logic                              vld_p2_q;
    logic                              last_p2_q;
    logic signed [OUT_WIDTH-1:0]       data_p2_q;
    logic signed [OUT_WIDTH-1:0]       data_p2_d;
    logic        [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    logic                              s1_en;
    logic                              s2_en;
    logic                              fire;
    logic signed [WIN_POW2:0]          win_ext;
    logic signed [PROD_W-1:0]          samp_x;
    logic signed [PROD_W-1:0]          win_x;

    assign s2_en = ~vld_p2_q | data_out_ready;
    assign s1_en = ~vld_p1_q | s2_en;

    assign fire            = sample_in_valid & win_in_valid & s1_en;
    assign sample_in_ready = win_in_valid & s1_en;
    assign win_in_ready    = sample_in_valid & s1_en;

    assign win_ext   = {1'b0, win_in};
    assign samp_x    = PROD_W'(sample_in);
    assign win_x     = PROD_W'(win_ext);
    assign prod_p1_d = samp_x * win_x;
    assign data_p2_d = round_sat(prod_p1_q);

    // Stage 1: joined product
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (s1_en) begin
            vld_p1_q <= fire;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            prod_p1_q <= prod_p1_d;
            last_p1_q <= win_in_last;
        end
    end

    // Stage 2: rounded, saturated output
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            data_p2_q <= '0;
        end else if (s2_en) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= data_p2_d;
                last_p2_q <= last_p1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (vld_p2_q & data_out_ready & last_p2_q) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign data_out       = data_p2_q;
    assign data_out_valid = vld_p2_q;
    assign data_out_last  = last_p2_q;
    assign frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_window_apply.sv
// Scoreboard bench for window_apply: default instance plus an 8-bit-output
// instance for saturation.
module tb_window_apply;

    typedef struct {
        int data;
        bit last;
        int fcyc;
        bit lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];
    exp_t sb8_q[$];

    // default instance
    logic signed [15:0] sample_in = '0;
    logic               sample_in_valid = 1'b0;
    logic               sample_in_ready;
    logic        [9:0]  win_in = '0;
    logic               win_in_valid = 1'b0;
    logic               win_in_last = 1'b0;
    logic               win_in_ready;
    logic signed [15:0] data_out;
    logic               data_out_valid;
    logic               data_out_last;
    logic               data_out_ready = 1'b1;
    logic        [15:0] frame_count;

    // narrow-output instance
    logic signed [15:0] s8_sample = '0;
    logic               s8_sample_valid = 1'b0;
    logic               s8_sample_ready;
    logic        [9:0]  s8_win = '0;
    logic               s8_win_valid = 1'b0;
    logic               s8_win_last = 1'b0;
    logic               s8_win_ready;
    logic signed [7:0]  s8_data;
    logic               s8_data_valid;
    logic               s8_data_last;
    logic        [15:0] s8_frame_count;

    window_apply dut (
        .clk(clk), .rst(rst),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(sample_in_ready),
        .win_in(win_in), .win_in_valid(win_in_valid), .win_in_last(win_in_last), .win_in_ready(win_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_last(data_out_last),
        .data_out_ready(data_out_ready), .frame_count(frame_count)
    );

    window_apply #(.OUT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .sample_in(s8_sample), .sample_in_valid(s8_sample_valid), .sample_in_ready(s8_sample_ready),
        .win_in(s8_win), .win_in_valid(s8_win_valid), .win_in_last(s8_win_last), .win_in_ready(s8_win_ready),
        .data_out(s8_data), .data_out_valid(s8_data_valid), .data_out_last(s8_data_last),
        .data_out_ready(1'b1), .frame_count(s8_frame_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: half-up rounding at 1.0 = 512, clamp to ow-bit signed range.
    function automatic int model(input int s, input int w, input int ow);
        int r;
        int mx;
        r  = (s * w + 256) >>> 9;
        mx = (1 << (ow - 1)) - 1;
        if (r > mx) r = mx;
        if (r < -mx - 1) r = -mx - 1;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && data_out_valid && data_out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d expected none", data_out);
            end else begin
                e = sb_q.pop_front();
                chk("data_out", int'(data_out), e.data);
                chk("data_out_last", int'(data_out_last), int'(e.last));
                if (e.lat) chk("latency", cyc - e.fcyc, 2);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s8_data_valid) begin
            if (sb8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got %0d expected none", s8_data);
            end else begin
                e = sb8_q.pop_front();
                chk("data_out8", int'(s8_data), e.data);
            end
        end
    end

    // Offer one pair and wait (bounded) until it fires; expected result is queued at the fire.
    task automatic send(input bit narrow, input int s, input int w, input bit l,
                        input int expv, input bit lat);
        int  n = 0;
        bit  acc = 1'b0;
        exp_t e;
        if (narrow) begin
            s8_sample = s[15:0]; s8_win = w[9:0]; s8_win_last = l;
            s8_sample_valid = 1'b1; s8_win_valid = 1'b1;
        end else begin
            sample_in = s[15:0]; win_in = w[9:0]; win_in_last = l;
            sample_in_valid = 1'b1; win_in_valid = 1'b1;
        end
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = narrow ? (s8_sample_ready & s8_win_ready) : (sample_in_ready & win_in_ready);
            if (acc) begin
                e.data = expv; e.last = l; e.fcyc = cyc; e.lat = lat;
                if (narrow) sb8_q.push_back(e);
                else sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
        if (narrow) begin
            s8_sample_valid = 1'b0; s8_win_valid = 1'b0; s8_win_last = 1'b0;
        end else begin
            sample_in_valid = 1'b0; win_in_valid = 1'b0; win_in_last = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || sb8_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0 || sb8_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size() + sb8_q.size());
            sb_q.delete();
            sb8_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sv;
        int wv;
        int hold_data;
        int hold_last;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(data_out_valid), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_last", int'(data_out_last), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        @(posedge clk);
        #1;

        // Basic scaling, consecutive beats, latency
        send(1'b0, 1000, 512, 1'b0, 1000, 1'b1);
        send(1'b0, 1000, 256, 1'b0, 500, 1'b1);
        send(1'b0, -1000, 256, 1'b0, -500, 1'b1);
        send(1'b0, 0, 0, 1'b0, 0, 1'b1);
        wait_drain();

        // Half-up rounding
        send(1'b0, 3, 256, 1'b0, 2, 1'b1);
        send(1'b0, -3, 256, 1'b0, -1, 1'b1);
        send(1'b0, 1, 256, 1'b0, 1, 1'b1);
        wait_drain();

        // Saturation on the 8-bit instance
        send(1'b1, 300, 512, 1'b0, 127, 1'b0);
        send(1'b1, -300, 512, 1'b0, -128, 1'b0);
        wait_drain();

        // Backpressure: 5-cycle stall in the middle of 8 beats
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    sv = 100 * (i + 1) - 350;
                    wv = 64 * i + 100;
                    send(1'b0, sv, wv, 1'b0, model(sv, wv, 16), 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                data_out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_valid", int'(data_out_valid), 1);
                    if (k == 0) begin
                        hold_data = int'(data_out);
                        hold_last = int'(data_out_last);
                    end else begin
                        chk("stall_data_stable", int'(data_out), hold_data);
                        chk("stall_last_stable", int'(data_out_last), hold_last);
                        chk("stall_sample_ready", int'(sample_in_ready), 0);
                        chk("stall_win_ready", int'(win_in_ready), 0);
                    end
                    @(posedge clk);
                    #1;
                end
                data_out_ready = 1'b1;
            end
        join
        wait_drain();

        // Unbalanced valids: sample waits for its coefficient
        sample_in = 16'sd500;
        win_in = 10'd256;
        sample_in_valid = 1'b1;
        win_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("unbal_sample_ready", int'(sample_in_ready), 0);
            chk("unbal_no_output", int'(data_out_valid), 0);
            @(posedge clk);
            #1;
        end
        send(1'b0, 500, 256, 1'b0, 250, 1'b1);
        wait_drain();

        // Full 1024-beat triangle frame
        for (int i = 0; i < 1024; i++) begin
            wv = (i < 512) ? 2 * i : 2 * (1023 - i);
            sv = ((i * 37) % 2001) - 1000;
            send(1'b0, sv, wv, i == 1023, model(sv, wv, 16), 1'b0);
        end
        wait_drain();
        @(negedge clk);
        chk("frame_count_one", int'(frame_count), 1);
        @(posedge clk);
        #1;

        // Reset in the middle of the second frame discards in-flight beats
        for (int i = 0; i < 10; i++) begin
            send(1'b0, i * 10, 2 * i, 1'b0, model(i * 10, 2 * i, 16), 1'b0);
        end
        sample_in_valid = 1'b1;
        win_in_valid = 1'b1;
        data_out_ready = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample_in_valid = 1'b0;
        win_in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(data_out_valid), 0);
        chk("post_rst_frame_count", int'(frame_count), 0);
        data_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
